dac_bias_servo: RTL

Closed-loop DAC bias servo. It consumes per-window zero counts from the bit-balance monitor, averages 2^AVG_LOG2 windows, and steps the DAC code toward the target count. Adds a saturating code range, lock detection and a parametrised settle delay. Sits between the zero-count monitor and the I2C DAC writer; dac_update triggers one I2C write.

---
 rtl/dac_servo_pkg.sv | 21 ++
 rtl/servo_settle_timer.sv | 50 +++++
 rtl/dac_bias_servo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dac_servo_pkg.sv
// Shared definitions for the DAC bias servo: FSM state encoding and the
// code clamp used when stepping the DAC code.
package dac_servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_SETTLE = 2'd3
  } servo_state_e;

  // Clamp a candidate code into [lo, hi].
  function automatic int clamp_code(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_settle_timer.sv
// Settle delay timer: after a start pulse it counts 0..SETTLE_CYCLES-1 and
// raises done during the final count. clear aborts a running count.
module servo_settle_timer #(
  parameter int SETTLE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state logic for the counter; done marks the last settle cycle.
  always_comb begin
    done     = active_q && (cnt_q == CW'(SETTLE_CYCLES - 1));
    active_d = active_q;
    cnt_d    = cnt_q;
    if (clear) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_bias_servo.sv
// Closed-loop DAC bias servo. Averages 2^AVG_LOG2 zero-count windows, steps
// the DAC code toward TARGET outside a deadband, waits SETTLE_CYCLES after
// every code change, and reports lock and saturation status.
// Build option: define DAC_SERVO_COARSE_STEP_EN to use an 8*STEP correction
// when the error exceeds 8*DEADBAND.
module dac_bias_servo
  import dac_servo_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int DAC_W         = 12,
  parameter int TARGET        = 32768,
  parameter int DEADBAND      = 1000,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 1000000,
  parameter int AVG_LOG2      = 0,
  parameter int START_CODE    = 700,
  parameter int DAC_MIN       = 0,
  parameter int DAC_MAX       = 4095,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             loop_en,
  input  logic             meas_valid,
  input  logic [CNT_W-1:0] meas_count,
  output logic [DAC_W-1:0] dac_code,
  output logic             dac_update,
  output logic             settling,
  output logic             locked,
  output logic             sat_hi,
  output logic             sat_lo
);

  localparam int SUM_W  = CNT_W + AVG_LOG2;
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int SCNT_W = AVG_LOG2 + 1;
  localparam int LCK_W  = $clog2(LOCK_COUNT + 1);
  localparam logic signed [CNT_W+1:0] TGT_S = (CNT_W + 2)'(TARGET);
  localparam logic signed [CNT_W+1:0] DB_S  = (CNT_W + 2)'(DEADBAND);
`ifdef DAC_SERVO_COARSE_STEP_EN
  localparam logic signed [CNT_W+1:0] CDB_S = (CNT_W + 2)'(8 * DEADBAND);
`endif

  servo_state_e            state_q, state_d;
  logic [DAC_W-1:0]        dac_code_q, dac_code_d;
  logic                    upd_q, upd_d;
  logic                    locked_q, locked_d;
  logic                    sat_hi_q, sat_hi_d;
  logic                    sat_lo_q, sat_lo_d;
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [SCNT_W-1:0]       smp_q, smp_d;
  logic [LCK_W-1:0]        lock_q, lock_d;
  logic [CNT_W-1:0]        avg;
  logic signed [CNT_W+1:0] err;
  logic                    tmr_start, tmr_clear, tmr_done, oob;
  int                      code_i, step_i, up_i, dn_i, new_i;

  servo_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .start    (tmr_start),
    .clear    (tmr_clear),
    .done     (tmr_done)
  );

  assign avg = CNT_W'(sum_q >> AVG_LOG2);
  assign err = $signed({2'b00, avg}) - TGT_S;

  // Servo FSM next-state, code arithmetic, lock and saturation tracking.
  always_comb begin
    state_d    = state_q;
    dac_code_d = dac_code_q;
    upd_d      = 1'b0;
    locked_d   = locked_q;
    sat_hi_d   = sat_hi_q;
    sat_lo_d   = sat_lo_q;
    sum_d      = sum_q;
    smp_d      = smp_q;
    lock_d     = lock_q;
    tmr_start  = 1'b0;
    tmr_clear  = 1'b0;
    oob        = 1'b0;
    code_i     = int'(dac_code_q);
    step_i     = STEP;
`ifdef DAC_SERVO_COARSE_STEP_EN
    if (err > CDB_S || err < -CDB_S) step_i = 8 * STEP;
`endif
    up_i  = code_i + step_i;
    dn_i  = code_i - step_i;
    new_i = code_i;

    if (!loop_en) begin
      state_d   = ST_IDLE;
      sum_d     = '0;
      smp_d     = '0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          smp_d   = '0;
        end
        ST_ACCUM: begin
          if (meas_valid) begin
            sum_d = sum_q + SUM_W'(meas_count);
            if (smp_q == SCNT_W'(NSAMP - 1)) begin
              smp_d   = '0;
              state_d = ST_DECIDE;
            end else begin
              smp_d = smp_q + SCNT_W'(1);
            end
          end
        end
        ST_DECIDE: begin
          sum_d = '0;
          smp_d = '0;
          if (err > DB_S) begin
            oob      = 1'b1;
            new_i    = clamp_code(up_i, DAC_MIN, DAC_MAX);
            sat_hi_d = (up_i > DAC_MAX);
            sat_lo_d = 1'b0;
          end else if (err < -DB_S) begin
            oob      = 1'b1;
            new_i    = clamp_code(dn_i, DAC_MIN, DAC_MAX);
            sat_lo_d = (dn_i < DAC_MIN);
            sat_hi_d = 1'b0;
          end else begin
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
            if (lock_q != LCK_W'(LOCK_COUNT)) lock_d = lock_q + LCK_W'(1);
            locked_d = (lock_d == LCK_W'(LOCK_COUNT));
            state_d  = ST_ACCUM;
          end
          if (oob) begin
            lock_d   = '0;
            locked_d = 1'b0;
            if (new_i != code_i) begin
              dac_code_d = DAC_W'(new_i);
              upd_d      = 1'b1;
              tmr_start  = 1'b1;
              state_d    = ST_SETTLE;
            end else begin
              state_d = ST_ACCUM;
            end
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            state_d = ST_ACCUM;
            sum_d   = '0;
            smp_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset restores the power-on operating point.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      dac_code_q <= DAC_W'(START_CODE);
      upd_q      <= 1'b0;
      locked_q   <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      sum_q      <= '0;
      smp_q      <= '0;
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      dac_code_q <= dac_code_d;
      upd_q      <= upd_d;
      locked_q   <= locked_d;
      sat_hi_q   <= sat_hi_d;
      sat_lo_q   <= sat_lo_d;
      sum_q      <= sum_d;
      smp_q      <= smp_d;
      lock_q     <= lock_d;
    end
  end

  assign dac_code   = dac_code_q;
  assign dac_update = upd_q;
  assign settling   = (state_q == ST_SETTLE);
  assign locked     = locked_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;

endmodule
